// File: rtl/phase_clk_ila_if.sv
// Bus bundle for phase_clk_ila: probe/trigger/readout inputs and status outputs.
// The master side drives the probe, the trigger setup and the read address.
// The slave side is the capture core.
interface phase_clk_ila_if #(
  parameter int PROBE_W = 2,
  parameter int ADDR_W  = 10
);
  logic [PROBE_W-1:0] probe0;
  logic               arm;
  logic [PROBE_W-1:0] trig_mask;
  logic [PROBE_W-1:0] trig_value;
  logic [ADDR_W-1:0]  rd_addr;
  logic               locked;
  logic [2:0]         ph_en;
  logic               armed;
  logic               capturing;
  logic               done;
  logic [ADDR_W:0]    sample_count;
  logic [PROBE_W-1:0] rd_data;

  modport master (
    output probe0, arm, trig_mask, trig_value, rd_addr,
    input  locked, ph_en, armed, capturing, done, sample_count, rd_data
  );

  modport slave (
    input  probe0, arm, trig_mask, trig_value, rd_addr,
    output locked, ph_en, armed, capturing, done, sample_count, rd_data
  );
endinterface

// File: rtl/phase_clk_ila.sv
// phase_clk_ila: single-clock stand-in for a 3-phase PLL plus logic analyser.
// It produces a lock flag and rotating one-hot phase enables.
// A triggered capture buffer stores probe0 on every sample phase (ph_en[0]).
// The buffer is a plain array with a registered read, so it can map to block RAM.
module phase_clk_ila #(
  parameter int PROBE_W     = 2,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int LOCK_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  phase_clk_ila_if.slave bus
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  logic [LOCK_W-1:0]  lock_cnt_reg;
  logic               locked_reg;
  logic [2:0]         ph_en_reg;

  state_t             state_reg;
  state_t             state_next;
  logic [ADDR_W:0]    count_reg;
  logic [ADDR_W:0]    count_next;

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [PROBE_W-1:0] mem [DEPTH];
  logic [PROBE_W-1:0] rd_data_reg;

  logic               sample_phase;
  logic               trig_hit;

  // Lock counter and phase rotation; the counter freezes once locked so it cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt_reg <= '0;
      locked_reg   <= 1'b0;
      ph_en_reg    <= 3'b000;
    end else if (!locked_reg) begin
      lock_cnt_reg <= lock_cnt_reg + LOCK_W'(1);
      if (lock_cnt_reg == LOCK_LAST) begin
        locked_reg <= 1'b1;
        ph_en_reg  <= 3'b001;
      end
    end else begin
      ph_en_reg <= {ph_en_reg[1:0], ph_en_reg[2]};
    end
  end

  assign sample_phase = ph_en_reg[0];
  assign trig_hit     = ((bus.probe0 ^ bus.trig_value) & bus.trig_mask) == '0;

  // Capture FSM state register and stored-sample counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic and buffer write control; writes happen only on sample phases.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    wr_en      = 1'b0;
    wr_addr    = count_reg[ADDR_W-1:0];
    case (state_reg)
      S_IDLE: begin
        if (bus.arm && locked_reg) begin
          state_next = S_ARMED;
          count_next = '0;
        end
      end
      S_ARMED: begin
        if (sample_phase && trig_hit) begin
          wr_en      = 1'b1;
          wr_addr    = '0;
          count_next = ONE_CNT;
          state_next = (ONE_CNT == DEPTH_CNT) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (sample_phase) begin
          wr_en      = 1'b1;
          count_next = count_reg + ONE_CNT;
          if (count_next == DEPTH_CNT) begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.arm) begin
          state_next = S_ARMED;
          count_next = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
        count_next = '0;
      end
    endcase
  end

  // Buffer write port; contents survive reset, and no write lands on the reset edge.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_addr] <= bus.probe0;
    end
  end

  // Registered read port; a same-edge write to the same address yields the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[bus.rd_addr];
    end
  end

  assign bus.locked       = locked_reg;
  assign bus.ph_en        = ph_en_reg;
  assign bus.armed        = (state_reg == S_ARMED);
  assign bus.capturing    = (state_reg == S_CAPTURE);
  assign bus.done         = (state_reg == S_DONE);
  assign bus.sample_count = count_reg;
  assign bus.rd_data      = rd_data_reg;

endmodule

// File: tb/tb_phase_clk_ila.sv
// Testbench for phase_clk_ila (DEPTH=8, LOCK_CYCLES=4).
// A behavioural model derives lock and phase from the number of cycles since reset release.
// Captured samples are held in a plain array, and every DUT output is compared against it.
module tb_phase_clk_ila;
  localparam int PROBE_W     = 2;
  localparam int DEPTH       = 8;
  localparam int ADDR_W      = 3;
  localparam int LOCK_CYCLES = 4;

  localparam int M_IDLE    = 0;
  localparam int M_ARMED   = 1;
  localparam int M_CAPTURE = 2;
  localparam int M_DONE    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  phase_clk_ila_if #(.PROBE_W(PROBE_W), .ADDR_W(ADDR_W)) bus ();

  phase_clk_ila #(
    .PROBE_W(PROBE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         rel = 0;        // non-reset cycles since reset release
  int         mode = M_IDLE;
  int         cnt = 0;
  logic [1:0] mem_m [DEPTH];
  bit         mem_known [DEPTH];
  logic [1:0] exp_rd = 2'b00;
  bit         exp_rd_known = 1'b0;

  function automatic logic [2:0] model_ph(int r);
    if (r < LOCK_CYCLES) return 3'b000;
    return 3'(1 << ((r - LOCK_CYCLES) % 3));
  endfunction

  function automatic logic [10:0] model_out();
    return {(rel >= LOCK_CYCLES), model_ph(rel), (mode == M_ARMED),
            (mode == M_CAPTURE), (mode == M_DONE), 4'(cnt)};
  endfunction

  function automatic logic [10:0] dut_out();
    return {bus.locked, bus.ph_en, bus.armed, bus.capturing, bus.done, bus.sample_count};
  endfunction

  // Advance the model by one clock using the inputs currently applied, then clock the DUT.
  task automatic tick();
    logic [2:0] ph_now;
    bit         hit;
    int         a;
    ph_now = model_ph(rel);
    hit = ((bus.probe0 ^ bus.trig_value) & bus.trig_mask) == 2'b00;
    if (rst) begin
      rel = 0; mode = M_IDLE; cnt = 0;
      exp_rd = 2'b00; exp_rd_known = 1'b1;
    end else begin
      a = int'(bus.rd_addr);
      exp_rd = mem_m[a];
      exp_rd_known = mem_known[a];
      case (mode)
        M_IDLE: if (bus.arm && rel >= LOCK_CYCLES) begin mode = M_ARMED; cnt = 0; end
        M_ARMED: if (ph_now[0] && hit) begin
          mem_m[0] = bus.probe0; mem_known[0] = 1'b1; cnt = 1;
          mode = (cnt == DEPTH) ? M_DONE : M_CAPTURE;
        end
        M_CAPTURE: if (ph_now[0]) begin
          mem_m[cnt % DEPTH] = bus.probe0; mem_known[cnt % DEPTH] = 1'b1;
          cnt++;
          if (cnt == DEPTH) mode = M_DONE;
        end
        default: if (bus.arm) begin mode = M_ARMED; cnt = 0; end
      endcase
      rel++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_tab [7];
    exp_tab = '{4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b1010, 4'b1100, 4'b1001};
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({dut_out(), bus.rd_data} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: got %b required %b", {dut_out(), bus.rd_data}, 13'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if ({bus.locked, bus.ph_en} !== exp_tab[i]) begin
        errors++;
        $display("FAIL lock_phase cycle %0d: got %b required %b", i + 1, {bus.locked, bus.ph_en}, exp_tab[i]);
      end
    end
    $display("reset/lock sequence done at rel=%0d", rel);
  endtask

  task automatic test_arm_lock();
    int n;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    checks++;
    if (bus.armed !== 1'b0) begin
      errors++;
      $display("FAIL arm_before_lock: armed got %b required 0", bus.armed);
    end
    n = 0;
    while (bus.locked !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_timeout: locked got %b required 1", bus.locked);
    end
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    checks++;
    if (bus.armed !== 1'b1 || dut_out() !== model_out()) begin
      errors++;
      $display("FAIL arm_after_lock: got %b required %b", dut_out(), model_out());
    end
    $display("arm after lock: armed=%b", bus.armed);
  endtask

  task automatic test_trigger();
    int n;
    bus.trig_mask = 2'b11; bus.trig_value = 2'b10; bus.probe0 = 2'b00;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL trig_wait cycle %0d: got %b required %b", i, dut_out(), model_out());
      end
    end
    bus.probe0 = 2'b10;
    n = 0;
    while (mode != M_CAPTURE && n < 10) begin
      tick(); n++;
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL trig_hit cycle %0d: got %b required %b", n, dut_out(), model_out());
      end
    end
    checks++;
    if (bus.capturing !== 1'b1 || bus.sample_count !== 4'd1) begin
      errors++;
      $display("FAIL trigger: capturing=%b count=%0d required 1 and 1", bus.capturing, bus.sample_count);
    end
    bus.rd_addr = 3'd0;
    tick();
    tick();
    checks++;
    if (bus.rd_data !== 2'b10) begin
      errors++;
      $display("FAIL trig_sample: mem[0] got %b required 10", bus.rd_data);
    end
    $display("trigger captured mem[0]=%b count=%0d", bus.rd_data, bus.sample_count);
  endtask

  task automatic test_fill();
    int n;
    n = 0;
    while (mode != M_DONE && n < 60) begin
      bus.probe0 = 2'($urandom);
      bus.arm = ($urandom_range(0, 7) == 0);
      bus.rd_addr = 3'($urandom);
      tick(); n++;
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL fill cycle %0d: got %b required %b", n, dut_out(), model_out());
      end
      if (exp_rd_known) begin
        checks++;
        if (bus.rd_data !== exp_rd) begin
          errors++;
          $display("FAIL fill_read cycle %0d: got %b required %b", n, bus.rd_data, exp_rd);
        end
      end
    end
    bus.arm = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.sample_count !== 4'd8) begin
      errors++;
      $display("FAIL fill_done: done=%b count=%0d required 1 and 8", bus.done, bus.sample_count);
    end
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr = 3'(a);
      bus.probe0 = 2'($urandom);
      tick();
      checks++;
      if (bus.rd_data !== mem_m[a] || dut_out() !== model_out()) begin
        errors++;
        $display("FAIL readout addr %0d: data %b status %b required %b status %b",
                 a, bus.rd_data, dut_out(), mem_m[a], model_out());
      end
      $display("read addr=%0d data=%b", a, bus.rd_data);
    end
  endtask

  task automatic test_rearm();
    int n;
    bus.trig_mask = 2'b00;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    checks++;
    if (bus.armed !== 1'b1 || bus.done !== 1'b0 || bus.sample_count !== 4'd0) begin
      errors++;
      $display("FAIL rearm: armed=%b done=%b count=%0d required 1 0 0", bus.armed, bus.done, bus.sample_count);
    end
    n = 0;
    while (mode != M_CAPTURE && n < 6) begin
      bus.arm = (n == 0);
      bus.probe0 = 2'($urandom);
      tick(); n++;
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL rearm_wait cycle %0d: got %b required %b", n, dut_out(), model_out());
      end
    end
    bus.arm = 1'b0;
    checks++;
    if (bus.capturing !== 1'b1 || bus.sample_count !== 4'd1) begin
      errors++;
      $display("FAIL rearm_trigger: capturing=%b count=%0d required 1 and 1", bus.capturing, bus.sample_count);
    end
    $display("re-armed trigger stored %b at addr 0", mem_m[0]);
  endtask

  task automatic test_rst_mid_capture();
    int n;
    n = 0;
    while (cnt < 3 && n < 12) begin
      bus.probe0 = 2'($urandom);
      tick(); n++;
    end
    checks++;
    if (bus.sample_count !== 4'd3 || bus.capturing !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst: count=%0d capturing=%b required 3 and 1", bus.sample_count, bus.capturing);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.capturing !== 1'b0 || bus.sample_count !== 4'd0 || bus.locked !== 1'b0 || bus.armed !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: status %b required %b", dut_out(), 11'd0);
    end
    rst = 1'b0;
    repeat (LOCK_CYCLES) tick();
    for (int a = 0; a < 3; a++) begin
      bus.rd_addr = 3'(a);
      tick();
      checks++;
      if (bus.rd_data !== mem_m[a]) begin
        errors++;
        $display("FAIL retained addr %0d: got %b required %b", a, bus.rd_data, mem_m[a]);
      end
      $display("retained read addr=%0d data=%b", a, bus.rd_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus.arm = ($urandom_range(0, 5) == 0);
      bus.probe0 = 2'($urandom);
      bus.trig_mask = 2'($urandom);
      bus.trig_value = 2'($urandom);
      bus.rd_addr = 3'($urandom);
      tick();
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL random cycle %0d: got %b required %b", i, dut_out(), model_out());
      end
      if (exp_rd_known) begin
        checks++;
        if (bus.rd_data !== exp_rd) begin
          errors++;
          $display("FAIL random_read cycle %0d: got %b required %b", i, bus.rd_data, exp_rd);
        end
      end
    end
    rst = 1'b0;
    $display("random phase finished, rel=%0d mode=%0d", rel, mode);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = 2'b00;
      mem_known[i] = 1'b0;
    end
    bus.probe0 = 2'b00;
    bus.arm = 1'b0;
    bus.trig_mask = 2'b11;
    bus.trig_value = 2'b10;
    bus.rd_addr = 3'd0;
    #1;
    test_reset();
    test_arm_lock();
    test_trigger();
    test_fill();
    test_rearm();
    test_rst_mid_capture();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
